// File: rtl/bmf_pkg.sv
// Shared types and the Boolean/GF(2) semiring column product for the BMF H decoder.
package bmf_pkg;

  typedef enum logic [1:0] {StRun, StDrain, StCfg} state_e;

  // Upper bound on K supported by semiring_col (operands are zero-extended to this width).
  localparam int unsigned MaxK = 32;

  // One output bit: OR (or XOR when gf2) over i of k[i] AND hcol[i].
  function automatic logic semiring_col(input logic [MaxK-1:0] k,
                                        input logic [MaxK-1:0] hcol,
                                        input logic            gf2);
    logic [MaxK-1:0] terms;
    terms = k & hcol;
    return gf2 ? ^terms : |terms;
  endfunction

endpackage

// File: rtl/bmf_pipe_stage.sv
// Valid/ready register slice; accepts whenever empty or being drained this cycle.
module bmf_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/bmf_h_decoder.sv
// Boolean matrix-factorisation decoder: out_y = in_k (x) H over a 2-stage valid/ready pipeline.
// Optional macro BMF_GF2_MODE_EN adds a per-vector mode_gf2 input selecting XOR accumulation.
module bmf_h_decoder import bmf_pkg::*; #(
  parameter int unsigned K = 4,
  parameter int unsigned M = 5,
  localparam int unsigned RowW = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clk,
  input  logic            rst,
`ifdef BMF_GF2_MODE_EN
  input  logic            mode_gf2,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [K-1:0]    in_k,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M-1:0]    out_y,
  input  logic            cfg_req,
  output logic            cfg_ack,
  input  logic            cfg_we,
  input  logic [RowW-1:0] cfg_row,
  input  logic [M-1:0]    cfg_data
);

`ifdef BMF_GF2_MODE_EN
  localparam int unsigned S1W = K + 1;
`else
  localparam int unsigned S1W = K;
`endif

  state_e              state_q, state_d;
  logic [K-1:0][M-1:0] h_q;
  logic                s1_in_valid, s1_in_ready, s1_valid, s2_in_ready;
  logic [S1W-1:0]      s1_in_data, s1_data;
  logic [K-1:0]        s1_k;
  logic                gf2;
  logic [M-1:0]        prod;
  logic [MaxK-1:0]     col;

`ifdef BMF_GF2_MODE_EN
  assign s1_in_data = {mode_gf2, in_k};
  assign s1_k       = s1_data[K-1:0];
  assign gf2        = s1_data[K];
`else
  assign s1_in_data = in_k;
  assign s1_k       = s1_data;
  assign gf2        = 1'b0;
`endif

  assign in_ready    = (state_q == StRun) && s1_in_ready;
  assign s1_in_valid = in_valid && (state_q == StRun);
  assign cfg_ack     = (state_q == StCfg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (cfg_req) state_d = StDrain;
      StDrain: begin
        if (!cfg_req)                    state_d = StRun;
        else if (!s1_valid && !out_valid) state_d = StCfg;
      end
      StCfg:   if (!cfg_req) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // H only changes in CFG, which is entered with both stages empty and no new input accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
    end else if ((state_q == StCfg) && cfg_we && (32'(cfg_row) < K)) begin
      h_q[cfg_row] <= cfg_data;
    end
  end

  always_comb begin
    prod = '0;
    col  = '0;
    for (int unsigned j = 0; j < M; j++) begin
      col = '0;
      for (int unsigned i = 0; i < K; i++) col[i] = h_q[i][j];
      prod[j] = semiring_col(MaxK'(s1_k), col, gf2);
    end
  end

  bmf_pipe_stage #(
    .Width(S1W)
  ) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_in_valid),
    .in_ready (s1_in_ready),
    .in_data  (s1_in_data),
    .out_valid(s1_valid),
    .out_ready(s2_in_ready),
    .out_data (s1_data)
  );

  bmf_pipe_stage #(
    .Width(M)
  ) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_valid),
    .in_ready (s2_in_ready),
    .in_data  (prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_y)
  );

endmodule

// File: tb/tb_bmf_h_decoder.sv
// Directed bench for bmf_h_decoder (K=4, M=5): latency, streaming, backpressure, drain/CFG, reset.
module tb_bmf_h_decoder;

  localparam int K = 4;
  localparam int M = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [K-1:0] in_k;
  logic [M-1:0] out_y, cfg_data;
  logic         cfg_req, cfg_ack, cfg_we;
  logic [1:0]   cfg_row;
`ifdef BMF_GF2_MODE_EN
  logic         mode_gf2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bmf_h_decoder #(
    .K(K),
    .M(M)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef BMF_GF2_MODE_EN
    .mode_gf2 (mode_gf2),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_k     (in_k),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .cfg_req  (cfg_req),
    .cfg_ack  (cfg_ack),
    .cfg_we   (cfg_we),
    .cfg_row  (cfg_row),
    .cfg_data (cfg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_k = '0; out_ready = 1'b1;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_row = '0; cfg_data = '0;
`ifdef BMF_GF2_MODE_EN
    mode_gf2 = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 'd0);
    chk("rst_out_y", 32'(out_y), 'd0);
    chk("rst_cfg_ack", 32'(cfg_ack), 'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 'd1);

    // Load H rows 0..3 = 00010, 00100, 01000, 10000
    cfg_req = 1'b1;
    for (int n = 0; n < 10 && !cfg_ack; n++) @(negedge clk);
    chk("cfg_ack_rise", 32'(cfg_ack), 'd1);
    chk("cfg_in_ready", 32'(in_ready), 'd0);
    cfg_we = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cfg_row  = 2'(r);
      cfg_data = 5'b00010 << r;
      @(negedge clk);
    end
    cfg_we = 1'b0; cfg_req = 1'b0;
    @(negedge clk);

    // Single vector latency
    chk("run_in_ready", 32'(in_ready), 'd1);
    in_valid = 1'b1; in_k = 4'b1010;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat1_not_valid", 32'(out_valid), 'd0);
    @(negedge clk);
    chk("lat2_valid", 32'(out_valid), 'd1);
    chk("lat2_y", 32'(out_y), 'b10100);
    @(negedge clk);

    // 16 back-to-back vectors; with this H, y = k << 1
    for (int c = 0; c < 20; c++) begin
      if (c >= 2 && c <= 17) begin
        chk("stream_valid", 32'(out_valid), 'd1);
        chk("stream_y", 32'(out_y), 32'((c - 2) * 2));
      end else begin
        chk("stream_idle", 32'(out_valid), 'd0);
      end
      if (c < 16) chk("stream_in_ready", 32'(in_ready), 'd1);
      in_valid = (c < 16);
      in_k     = 4'(c);
      @(negedge clk);
    end

    // Backpressure: out_ready low for 5 cycles
    out_ready = 1'b0; in_valid = 1'b1; in_k = 4'd1;
    chk("bp_accept1", 32'(in_ready), 'd1);
    @(negedge clk);
    chk("bp_out_empty", 32'(out_valid), 'd0);
    chk("bp_accept2", 32'(in_ready), 'd1);
    in_k = 4'd2;
    @(negedge clk);
    chk("bp_in_ready_drop", 32'(in_ready), 'd0);
    chk("bp_valid", 32'(out_valid), 'd1);
    chk("bp_y", 32'(out_y), 'b00010);
    in_k = 4'd3;
    @(negedge clk);
    chk("bp_hold_y_a", 32'(out_y), 'b00010);
    chk("bp_hold_ready_a", 32'(in_ready), 'd0);
    @(negedge clk);
    chk("bp_hold_y_b", 32'(out_y), 'b00010);
    chk("bp_hold_valid_b", 32'(out_valid), 'd1);
    @(negedge clk);
    chk("bp_release_y", 32'(out_y), 'b00010);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 'd1);
    chk("bp_next_y", 32'(out_y), 'b00100);
    @(negedge clk);
    chk("bp_last_valid", 32'(out_valid), 'd1);
    chk("bp_last_y", 32'(out_y), 'b00110);
    @(negedge clk);
    chk("bp_done", 32'(out_valid), 'd0);

    // cfg_req with two beats in flight: both leave with old H before cfg_ack
    in_valid = 1'b1; in_k = 4'b0001;
    @(negedge clk);
    in_k = 4'b0100;
    @(negedge clk);
    in_valid = 1'b0; cfg_req = 1'b1;
    chk("drain_y0_valid", 32'(out_valid), 'd1);
    chk("drain_y0", 32'(out_y), 'b00010);
    chk("drain_ack0", 32'(cfg_ack), 'd0);
    @(negedge clk);
    chk("drain_y1_valid", 32'(out_valid), 'd1);
    chk("drain_y1", 32'(out_y), 'b01000);
    chk("drain_in_ready", 32'(in_ready), 'd0);
    chk("drain_ack1", 32'(cfg_ack), 'd0);
    in_valid = 1'b1; in_k = 4'b1111;
    @(negedge clk);
    chk("drain_empty", 32'(out_valid), 'd0);
    chk("drain_ack2", 32'(cfg_ack), 'd0);
    @(negedge clk);
    chk("drain_ack3", 32'(cfg_ack), 'd1);
    chk("drain_no_extra", 32'(out_valid), 'd0);
    in_valid = 1'b0; cfg_we = 1'b1; cfg_row = 2'd1; cfg_data = 5'b11111;
    @(negedge clk);
    cfg_we = 1'b0; cfg_req = 1'b0;
    @(negedge clk);
    chk("cfg_exit_ready", 32'(in_ready), 'd1);
    // write attempted in RUN must be ignored
    in_valid = 1'b1; in_k = 4'b0010; cfg_we = 1'b1; cfg_row = 2'd0; cfg_data = 5'b11111;
    @(negedge clk);
    cfg_we = 1'b0; in_k = 4'b0001;
    @(negedge clk);
    in_valid = 1'b0;
    chk("new_row1_valid", 32'(out_valid), 'd1);
    chk("new_row1_y", 32'(out_y), 'b11111);
    @(negedge clk);
    chk("row0_kept_y", 32'(out_y), 'b00010);
    @(negedge clk);

    // Reset while out_valid is high
    in_valid = 1'b1; in_k = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 'd1);
    chk("pre_rst_y", 32'(out_y), 'b11111);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 'd0);
    chk("async_rst_y", 32'(out_y), 'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_in_ready", 32'(in_ready), 'd1);
    in_valid = 1'b1; in_k = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst2_lat1", 32'(out_valid), 'd0);
    @(negedge clk);
    chk("rst2_valid", 32'(out_valid), 'd1);
    chk("rst2_h_cleared", 32'(out_y), 'd0);
    @(negedge clk);

`ifdef BMF_GF2_MODE_EN
    cfg_req = 1'b1;
    for (int n = 0; n < 10 && !cfg_ack; n++) @(negedge clk);
    chk("gf2_cfg_ack", 32'(cfg_ack), 'd1);
    cfg_we = 1'b1; cfg_row = 2'd0; cfg_data = 5'b00011;
    @(negedge clk);
    cfg_row = 2'd1; cfg_data = 5'b00110;
    @(negedge clk);
    cfg_we = 1'b0; cfg_req = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_k = 4'b0011; mode_gf2 = 1'b1;
    @(negedge clk);
    mode_gf2 = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("gf2_xor_y", 32'(out_y), 'b00101);
    @(negedge clk);
    chk("gf2_or_y", 32'(out_y), 'b00111);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bmf_h_decoder.md
BMF_H_DECODER -- requirements
Module: bmf_h_decoder

Interface
REQ-001 SHALL have parameter K, default 4, meaning latent vector width (rows of basis matrix H).
REQ-002 SHALL have parameter M, default 5, meaning reconstructed output width (columns of H).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid / in_ready / in_k, input/output/input, 1/1/K, latent-vector stream.
REQ-006 SHALL have port out_valid / out_ready / out_y, output/input/output, 1/1/M, reconstructed stream.
REQ-007 SHALL have port cfg_req, input, 1, request to enter basis-load mode.
REQ-008 SHALL have port cfg_ack, output, 1, high while basis writes are accepted.
REQ-009 SHALL have port cfg_we / cfg_row / cfg_data, input/input/input, 1/$clog2(K)/M, basis row write.

Function
REQ-010 SHALL compute out_y[j] = OR over i of (in_k[i] AND H[i][j]) (Boolean semiring product).
REQ-011 SHALL be a 2-stage pipeline: stage S1 registers the accepted in_k; stage S2 registers out_y.
REQ-012 SHALL present out_valid exactly 2 cycles after an in_valid&&in_ready beat with no backpressure; throughput one vector per cycle.
REQ-013 SHALL advance each stage when its successor is empty or being drained (stage ready = !valid || next ready); no bubbles under continuous flow.
REQ-014 SHALL hold out_y stable while out_valid && !out_ready.
REQ-015 SHALL preserve order; no beat dropped or duplicated under any in_valid/out_ready pattern.
REQ-016 SHALL implement FSM states RUN, DRAIN, CFG.
REQ-017 RUN: in_ready = S1 can advance; cfg_req=1 -> DRAIN.
REQ-018 DRAIN: in_ready=0; S1 and S2 continue to empty; both empty -> CFG; cfg_req dropped before empty -> RUN.
REQ-019 CFG: in_ready=0, cfg_ack=1; cfg_we writes H[cfg_row] <= cfg_data next edge; cfg_req=0 -> RUN.
REQ-020 SHALL ignore cfg_we outside CFG, and ignore writes with cfg_row >= K.
REQ-021 SHALL make a write in CFG visible to the first vector accepted after return to RUN.
REQ-022 SHALL use H unchanged for every in-flight vector (H never changes while S1/S2 hold data).

Reset
REQ-023 SHALL, on rst, asynchronously set state=RUN, H=all zero, S1/S2 valid=0, out_valid=0, out_y=0, cfg_ack=0; in_ready=1 from the first cycle after release.
REQ-024 SHALL, on rst mid-transfer or mid-CFG, discard in-flight data and H contents without emitting a partial beat.

Configuration
REQ-025 SHALL honour macro BMF_GF2_MODE_EN: when defined, add input mode_gf2 (1 bit) and, when mode_gf2=1, compute out_y[j] = XOR over i of (in_k[i] AND H[i][j]); mode_gf2 sampled with each vector at S1.
REQ-026 SHALL, without BMF_GF2_MODE_EN, have no mode_gf2 port and compute OR only.

Structure
REQ-027 SHALL place the FSM state enum and the semiring-product function in shared package bmf_pkg.
REQ-028 SHALL use one sub-module, bmf_pipe_stage (valid/ready register slice, width parameter), instantiated for S1 and S2.

Verification (K=4, M=5; H rows 0..3 = 00010, 00100, 01000, 10000)
REQ-029 Load H in CFG, cfg_req=0, in_k=4'b1010 -> out_y=5'b10100 two cycles later.
REQ-030 Continuous in_valid 16 vectors 0..15, out_ready=1 -> 16 outputs back-to-back, in order, cycles 2..17.
REQ-031 out_ready held 0 for 5 cycles with in_valid=1 -> in_ready drops after 2 accepts, out_y stable, no loss on release.
REQ-032 cfg_req=1 with 2 beats in flight -> both emerge with old H, cfg_ack rises only after out empty; write row1=11111, in_k=4'b0010 -> 5'b11111.
REQ-033 rst asserted with out_valid=1 -> out_valid=0 immediately; post-reset in_k=4'b1111 -> out_y=5'b00000 (H cleared).
REQ-034 With BMF_GF2_MODE_EN, H rows 0,1 = 00011, 00110, mode_gf2=1, in_k=4'b0011 -> out_y=5'b00101; mode_gf2=0 -> 5'b00111.
